// File: rtl/rev_alu_pkg.sv
// Shared constants for the reversible ALU: operation codes and the
// depth of the result buffer used between the logic unit and writeback.
package rev_alu_pkg;

   localparam logic [1:0] REV_OP_AND  = 2'b00;
   localparam logic [1:0] REV_OP_OR   = 2'b01;
   localparam logic [1:0] REV_OP_XOR  = 2'b10;
   localparam logic [1:0] REV_OP_XNOR = 2'b11;

   localparam int REV_BUF_DEPTH = 2;

endpackage

// File: rtl/rev_logic_slice.sv
// One-bit reversible logic slice built from Toffoli and Feynman gates.
// Optional feature macro: REV_ANCILLA_CHECK_EN -- when defined, the slice
// also reconstructs its operand bits from the gates' pass-through outputs
// so the top can confirm the gates behaved reversibly.

// Toffoli (CCNOT) gate: controls pass through, target flips when both set.
module toffoli (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_p,
   output logic o_q,
   output logic o_r
);
   assign o_p = i_a;
   assign o_q = i_b;
   assign o_r = i_c ^ (i_a & i_b);
endmodule

// Feynman (CNOT) gate: control passes through, target flips when control set.
module feynman (
   input  logic i_a,
   input  logic i_b,
   output logic o_p,
   output logic o_q
);
   assign o_p = i_a;
   assign o_q = i_a ^ i_b;
endmodule

module rev_logic_slice
   import rev_alu_pkg::*;
(
   input  logic       i_a,
   input  logic       i_b,
   input  logic [1:0] i_op,
   output logic       o_y
`ifdef REV_ANCILLA_CHECK_EN
   ,
   output logic       o_pa,
   output logic       o_pb
`endif
);

   logic w_na;
   logic w_nb;
   logic w_and;
   logic w_or;
   logic w_xor;
   logic w_xnor;

   assign w_na = ~i_a;
   assign w_nb = ~i_b;

`ifdef REV_ANCILLA_CHECK_EN
   logic w_andP;
   logic w_andQ;
   logic w_orP;
   logic w_orQ;
   logic w_xorP;
   logic w_invP;

   toffoli uAnd (.i_a(i_a),  .i_b(i_b),  .i_c(1'b0), .o_p(w_andP), .o_q(w_andQ), .o_r(w_and));
   toffoli uOr  (.i_a(w_na), .i_b(w_nb), .i_c(1'b1), .o_p(w_orP),  .o_q(w_orQ),  .o_r(w_or));
   feynman uXor (.i_a(i_a),  .i_b(i_b),  .o_p(w_xorP), .o_q(w_xor));
   feynman uInv (.i_a(1'b1), .i_b(w_xor), .o_p(w_invP), .o_q(w_xnor));

   // Recover the operand bits from the active gate's outputs; the XOR/XNOR
   // paths recover b by running the Feynman relation backwards.
   always_comb begin
      o_pa = w_xorP;
      o_pb = w_xorP ^ w_xor;
      case (i_op)
         REV_OP_AND: begin
            o_pa = w_andP;
            o_pb = w_andQ;
         end
         REV_OP_OR: begin
            o_pa = ~w_orP;
            o_pb = ~w_orQ;
         end
         REV_OP_XOR: begin
            o_pa = w_xorP;
            o_pb = w_xorP ^ w_xor;
         end
         default: begin
            o_pa = w_xorP;
            o_pb = w_xorP ^ (w_invP ^ w_xnor);
         end
      endcase
   end
`else
   toffoli uAnd (.i_a(i_a),  .i_b(i_b),  .i_c(1'b0), .o_p(), .o_q(), .o_r(w_and));
   toffoli uOr  (.i_a(w_na), .i_b(w_nb), .i_c(1'b1), .o_p(), .o_q(), .o_r(w_or));
   feynman uXor (.i_a(i_a),  .i_b(i_b),  .o_p(), .o_q(w_xor));
   feynman uInv (.i_a(1'b1), .i_b(w_xor), .o_p(), .o_q(w_xnor));
`endif

   // Select which gate target drives the slice result.
   always_comb begin
      o_y = w_and;
      case (i_op)
         REV_OP_AND:  o_y = w_and;
         REV_OP_OR:   o_y = w_or;
         REV_OP_XOR:  o_y = w_xor;
         default:     o_y = w_xnor;
      endcase
   end

endmodule

// File: rtl/rev_logic_unit.sv
// Pipelined reversible logic unit: WIDTH bit slices feed a two-entry
// result buffer with valid/ready on both sides and a completed-op counter.
// Optional feature macro: REV_ANCILLA_CHECK_EN -- enables the sticky
// anc_err flag that checks the gates' pass-through outputs on each accept.
module rev_logic_unit
   import rev_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_op,
   output logic [CNT_W-1:0] op_count,
   output logic             anc_err
);

   localparam logic [1:0] DEPTH_C = 2'(REV_BUF_DEPTH);

   logic [1:0]       r_count;
   logic [WIDTH-1:0] r_data [REV_BUF_DEPTH];
   logic [1:0]       r_op   [REV_BUF_DEPTH];
   logic [CNT_W-1:0] r_opCount;
   logic [WIDTH-1:0] w_result;
   logic             w_push;
   logic             w_pop;

`ifdef REV_ANCILLA_CHECK_EN
   logic [WIDTH-1:0] w_pa;
   logic [WIDTH-1:0] w_pb;
   logic             r_ancErr;
`endif

   // Bit slices are independent, so one instance per operand bit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : gSlice
      rev_logic_slice uSlice (
         .i_a  (in_a[gi]),
         .i_b  (in_b[gi]),
         .i_op (in_op),
         .o_y  (w_result[gi])
`ifdef REV_ANCILLA_CHECK_EN
         ,
         .o_pa (w_pa[gi]),
         .o_pb (w_pb[gi])
`endif
      );
   end

   // in_ready comes only from the registered count, so downstream ready
   // never reaches the upstream handshake combinationally.
   assign in_ready  = (r_count < DEPTH_C);
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_data[0];
   assign out_op    = r_op[0];
   assign op_count  = r_opCount;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Two-entry FIFO with the head always in slot 0; a pop shifts slot 1
   // forward, and a simultaneous push/pop can only happen with one entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         for (int i = 0; i < REV_BUF_DEPTH; i++) begin
            r_data[i] <= '0;
            r_op[i]   <= 2'b00;
         end
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               r_data[r_count[0]] <= w_result;
               r_op[r_count[0]]   <= in_op;
               r_count            <= r_count + 2'd1;
            end
            2'b01: begin
               r_data[0] <= r_data[1];
               r_op[0]   <= r_op[1];
               r_count   <= r_count - 2'd1;
            end
            2'b11: begin
               r_data[0] <= w_result;
               r_op[0]   <= in_op;
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   // Count results handed to writeback; wraps naturally at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opCount <= '0;
      end else if (w_pop) begin
         r_opCount <= r_opCount + CNT_W'(1);
      end
   end

`ifdef REV_ANCILLA_CHECK_EN
   // Reversible gates must hand back their inputs untouched; any
   // difference on an accepted beat latches an error until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ancErr <= 1'b0;
      end else if (w_push && ((w_pa != in_a) || (w_pb != in_b))) begin
         r_ancErr <= 1'b1;
      end
   end

   assign anc_err = r_ancErr;
`else
   assign anc_err = 1'b0;
`endif

endmodule

// File: tb/tb_rev_logic_unit.sv
// Self-checking bench for rev_logic_unit. A queue-based model of the
// result buffer predicts every output; results come from plain operators.
module tb_rev_logic_unit;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] d;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [1:0]       in_op = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_op;
   logic [CNT_W-1:0] op_count;
   logic             anc_err;

   beat_t       mq[$];
   int unsigned mPops = 0;
   int          tests = 0;
   int          failures = 0;

   rev_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_op    (out_op),
      .op_count  (op_count),
      .anc_err   (anc_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] refResult(logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] expCount();
      return CNT_W'(mPops);
   endfunction

   // Advance one clock from a falling edge to the next, updating the model.
   task automatic clockCycle(output bit accepted);
      bit pop;
      accepted = in_valid && (mq.size() < DEPTH);
      pop      = (mq.size() > 0) && out_ready;
      @(posedge clk);
      if (pop) begin
         void'(mq.pop_front());
         mPops++;
      end
      if (accepted) mq.push_back({in_op, refResult(in_op, in_a, in_b)});
      @(negedge clk);
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      mq.delete();
      mPops = 0;
      rst_n = 1'b1;
   endtask

   task automatic randomBeat();
      in_a  = WIDTH'($urandom());
      in_b  = WIDTH'($urandom());
      in_op = 2'($urandom_range(0, 3));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      randomBeat();
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
      end
      tests++;
      if (op_count !== '0) begin
         failures++;
         $display("[TB] FAIL reset_op_count got %0d want 0", op_count);
      end
      tests++;
      if (anc_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_anc_err got %b want 0", anc_err);
      end
      rst_n = 1'b1;
      mq.delete();
      mPops = 0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ops();
      logic [WIDTH-1:0] expTab [4];
      bit acc;
      expTab = '{8'h24, 8'hBD, 8'h99, 8'h66};
      applyReset();
      out_ready = 1'b1;
      for (int op = 0; op < 4; op++) begin
         in_a = 8'hA5;
         in_b = 8'h3C;
         in_op = 2'(op);
         in_valid = 1'b1;
         clockCycle(acc);
         in_valid = 1'b0;
         tests++;
         if (out_valid !== 1'b1 || out_data !== expTab[op] || out_op !== 2'(op)) begin
            failures++;
            $display("[TB] FAIL op%0d got v=%b d=%h op=%0d want v=1 d=%h op=%0d",
                     op, out_valid, out_data, out_op, expTab[op], op);
         end
         clockCycle(acc);
      end
      tests++;
      if (op_count !== expCount()) begin
         failures++;
         $display("[TB] FAIL ops_op_count got %0d want %0d", op_count, expCount());
      end
   endtask

   task automatic test_backpressure();
      beat_t first;
      bit acc;
      bit thirdIn;
      applyReset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         randomBeat();
         in_valid = 1'b1;
         tests++;
         if (in_ready !== (i < 2)) begin
            failures++;
            $display("[TB] FAIL bp_in_ready%0d got %b want %b", i, in_ready, (i < 2));
         end
         clockCycle(acc);
      end
      first = mq[0];
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (in_ready !== 1'b0 || out_data !== first.d || out_op !== first.op) begin
            failures++;
            $display("[TB] FAIL bp_hold%0d got rdy=%b d=%h op=%0d want rdy=0 d=%h op=%0d",
                     i, in_ready, out_data, out_op, first.d, first.op);
         end
         clockCycle(acc);
      end
      out_ready = 1'b1;
      thirdIn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (mq.size() > 0) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== mq[0].d || out_op !== mq[0].op) begin
               failures++;
               $display("[TB] FAIL bp_drain%0d got v=%b d=%h op=%0d want v=1 d=%h op=%0d",
                        i, out_valid, out_data, out_op, mq[0].d, mq[0].op);
            end
         end
         clockCycle(acc);
         if (acc) begin
            thirdIn = 1'b1;
            in_valid = 1'b0;
         end
      end
      tests++;
      if (!thirdIn || op_count !== 4'd3 || op_count !== expCount()) begin
         failures++;
         $display("[TB] FAIL bp_op_count got %0d accepted3=%b want 3", op_count, thirdIn);
      end
   endtask

   task automatic test_back_to_back();
      bit acc;
      applyReset();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         randomBeat();
         in_valid = 1'b1;
         if (i > 0) begin
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || mq.size() != 1 ||
                out_data !== mq[0].d || out_op !== mq[0].op) begin
               failures++;
               $display("[TB] FAIL b2b%0d got v=%b rdy=%b d=%h want v=1 rdy=1 d=%h",
                        i, out_valid, in_ready, out_data, mq[0].d);
            end
         end
         clockCycle(acc);
      end
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== mq[0].d) begin
         failures++;
         $display("[TB] FAIL b2b_last got v=%b d=%h want v=1 d=%h", out_valid, out_data, mq[0].d);
      end
      clockCycle(acc);
      tests++;
      if (out_valid !== 1'b0 || op_count !== 4'd10) begin
         failures++;
         $display("[TB] FAIL b2b_op_count got v=%b cnt=%0d want v=0 cnt=10", out_valid, op_count);
      end
   endtask

   task automatic test_wrap();
      bit acc;
      applyReset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         randomBeat();
         in_valid = 1'b1;
         clockCycle(acc);
      end
      in_valid = 1'b0;
      clockCycle(acc);
      tests++;
      if (op_count !== 4'd1 || op_count !== expCount()) begin
         failures++;
         $display("[TB] FAIL wrap_op_count got %0d want 1", op_count);
      end
   endtask

   task automatic test_mid_reset();
      bit acc;
      applyReset();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         randomBeat();
         in_valid = 1'b1;
         clockCycle(acc);
      end
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== '0) begin
         failures++;
         $display("[TB] FAIL midrst_async got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0",
                  out_valid, in_ready, op_count);
      end
      @(negedge clk);
      mq.delete();
      mPops = 0;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit acc;
      applyReset();
      for (int i = 0; i < 300; i++) begin
         randomBeat();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         tests++;
         if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH) ||
             op_count !== expCount() || anc_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rand%0d got v=%b rdy=%b cnt=%0d err=%b want v=%b rdy=%b cnt=%0d err=0",
                     i, out_valid, in_ready, op_count, anc_err,
                     (mq.size() > 0), (mq.size() < DEPTH), expCount());
         end
         if (mq.size() > 0) begin
            tests++;
            if (out_data !== mq[0].d || out_op !== mq[0].op) begin
               failures++;
               $display("[TB] FAIL rand_head%0d got d=%h op=%0d want d=%h op=%0d",
                        i, out_data, out_op, mq[0].d, mq[0].op);
            end
         end
         clockCycle(acc);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_ops();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
